// File: rtl/sel_split_stream_sync.sv
// sel_split_stream_sync: clocked selective fork of one upstream token to a
// channel-select subset of NUM_CH downstream channels. Each selected channel
// takes the token once, at its own pace. Upstream is released in the cycle the
// last pending channel handshakes, so back-to-back tokens flow with no bubbles.
// A token with an all-zero select mask is consumed and reported as dropped.
// Optional build macro SEL_SPLIT_STAT_EN adds per-channel 16-bit delivered-token
// counters (o_cnt) with a synchronous clear (i_clr).
module sel_split_stream_sync #(
    parameter int NUM_CH = 9,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [DATA_W-1:0]   i_data,
    input  logic [NUM_CH-1:0]   i_sel,
    output logic [NUM_CH-1:0]   o_valid,
    input  logic [NUM_CH-1:0]   i_ready,
    output logic [DATA_W-1:0]   o_data,
    output logic                o_done,
    output logic                o_drop
`ifdef SEL_SPLIT_STAT_EN
    ,
    output logic [NUM_CH*16-1:0] o_cnt,
    input  logic                 i_clr
`endif
);

    logic              busy, busyNext;
    logic [NUM_CH-1:0] pend, pendNext;
    logic [DATA_W-1:0] dataReg, dataNext;
    logic              doneReg, doneNext;
    logic              dropReg, dropNext;
    logic [NUM_CH-1:0] hs;
    logic              last;
    logic              acceptTok;
    logic              acceptDrop;

    // State register: busy flag, pending-channel mask, held payload, status pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy    <= 1'b0;
            pend    <= '0;
            dataReg <= '0;
            doneReg <= 1'b0;
            dropReg <= 1'b0;
        end else begin
            busy    <= busyNext;
            pend    <= pendNext;
            dataReg <= dataNext;
            doneReg <= doneNext;
            dropReg <= dropNext;
        end
    end

    // Output/handshake decode: per-channel valid, final-handshake detect, upstream ready
    always_comb begin
        o_valid    = pend & {NUM_CH{busy}};
        hs         = o_valid & i_ready;
        // last: every channel still pending is handshaking right now
        last       = busy & ((pend & ~hs) == '0);
        o_ready    = ~busy | last;
        acceptTok  = i_valid & o_ready & (|i_sel);
        acceptDrop = i_valid & o_ready & ~(|i_sel);
    end

    // Next state: load a new token, retire the current one, or clear delivered channels
    always_comb begin
        busyNext = busy;
        pendNext = pend & ~hs;
        dataNext = dataReg;
        if (acceptTok) begin
            // a new token overrides retirement of the old one in the same cycle
            busyNext = 1'b1;
            pendNext = i_sel;
            dataNext = i_data;
        end else if (last) begin
            busyNext = 1'b0;
            pendNext = '0;
        end
        doneNext = last | acceptDrop;
        dropNext = acceptDrop;
    end

    assign o_data = dataReg;
    assign o_done = doneReg;
    assign o_drop = dropReg;

`ifdef SEL_SPLIT_STAT_EN
    logic [15:0] cnt [NUM_CH];

    for (genvar k = 0; k < NUM_CH; k++) begin : gCnt
        // Per-channel delivered-token counter; clear wins over increment, wraps at 16 bits
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt[k] <= '0;
            end else if (i_clr) begin
                cnt[k] <= '0;
            end else if (hs[k]) begin
                cnt[k] <= cnt[k] + 16'd1;
            end
        end
        assign o_cnt[16*k +: 16] = cnt[k];
    end
`endif

endmodule

// File: tb/tb_sel_split_stream_sync.sv
// Bench for sel_split_stream_sync: directed scenarios plus random traffic,
// all checked cycle by cycle against a token-queue reference model.
module tb_sel_split_stream_sync;

    localparam int NUM_CH = 9;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              iValid = 1'b0;
    logic              oReady;
    logic [DATA_W-1:0] iData = '0;
    logic [NUM_CH-1:0] iSel = '0;
    logic [NUM_CH-1:0] oValid;
    logic [NUM_CH-1:0] iReady = '0;
    logic [DATA_W-1:0] oData;
    logic              oDone;
    logic              oDrop;
`ifdef SEL_SPLIT_STAT_EN
    logic [NUM_CH*16-1:0] oCnt;
    logic                 iClr = 1'b0;
`endif

    sel_split_stream_sync #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (iValid),
        .o_ready (oReady),
        .i_data  (iData),
        .i_sel   (iSel),
        .o_valid (oValid),
        .i_ready (iReady),
        .o_data  (oData),
        .o_done  (oDone),
        .o_drop  (oDrop)
`ifdef SEL_SPLIT_STAT_EN
        ,
        .o_cnt   (oCnt),
        .i_clr   (iClr)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: tokens still owed to channels, plus pulses due next cycle
    typedef struct {
        logic [DATA_W-1:0] data;
        logic [NUM_CH-1:0] left;
    } tok_t;
    tok_t tokQ[$];
    logic doneDue = 1'b0;
    logic dropDue = 1'b0;
    int   expDeliv [NUM_CH];
    int   obsDeliv [NUM_CH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model
    task automatic cycle(input logic v, input logic [DATA_W-1:0] d,
                         input logic [NUM_CH-1:0] s, input logic [NUM_CH-1:0] r);
        logic [NUM_CH-1:0] expValid;
        logic lastNow, expReady;
        iValid = v; iData = d; iSel = s; iReady = r;
        #2;
        expValid = (tokQ.size() > 0) ? tokQ[0].left : '0;
        lastNow  = (tokQ.size() > 0) && ((tokQ[0].left & ~r) == '0);
        expReady = (tokQ.size() == 0) || lastNow;
        chk("valid", oValid, expValid);
        chk("ready", oReady, expReady);
        chk("done",  oDone,  doneDue);
        chk("drop",  oDrop,  dropDue);
        if (tokQ.size() > 0) chk("data", oData, tokQ[0].data);
        for (int k = 0; k < NUM_CH; k++)
            if (oValid[k] && r[k]) obsDeliv[k]++;
        doneDue = lastNow;
        dropDue = 1'b0;
        if (tokQ.size() > 0) begin
            if (lastNow) void'(tokQ.pop_front());
            else tokQ[0].left = tokQ[0].left & ~r;
        end
        if (v && expReady) begin
            if (s == '0) begin
                dropDue = 1'b1;
                doneDue = 1'b1;
            end else begin
                tokQ.push_back('{data: d, left: s});
                for (int k = 0; k < NUM_CH; k++)
                    if (s[k]) expDeliv[k]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < NUM_CH; k++) begin
            expDeliv[k] = 0;
            obsDeliv[k] = 0;
        end
        #1;
        chk("rst_valid", oValid, 0);
        chk("rst_ready", oReady, 1);
        chk("rst_done",  oDone,  0);
        chk("rst_drop",  oDrop,  0);
        chk("rst_data",  oData,  0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        cycle(0, '0, '0, '1);

        // single fork
        cycle(1, 32'hA5A5_0001, 9'h005, '1);
        chk("t1_valid", oValid, 9'h005);
        chk("t1_data",  oData,  32'hA5A5_0001);
        cycle(0, '0, '0, '1);
        chk("t1_done", oDone, 1);
        cycle(0, '0, '0, '1);

        // staggered ready: channel k ready only in cycle k
        cycle(1, 32'h1234_5678, 9'h1FF, '0);
        for (int c = 0; c < NUM_CH; c++) cycle(1, 32'hDEAD_0000, 9'h003, 9'(1) << c);
        cycle(0, '0, '0, '1);
        cycle(0, '0, '0, '1);

        // back-to-back tokens
        cycle(1, 32'h0000_0011, 9'h001, '1);
        cycle(1, 32'h0000_0022, 9'h002, '1);
        cycle(1, 32'h0000_0033, 9'h004, '1);
        cycle(0, '0, '0, '1);
        cycle(0, '0, '0, '1);

        // empty mask, then a normal token
        cycle(1, 32'hBAD0_BAD0, 9'h000, '1);
        chk("t4_drop", oDrop, 1);
        cycle(1, 32'h600D_600D, 9'h010, '1);
        cycle(0, '0, '0, '1);
        cycle(0, '0, '0, '1);

        // reset in the middle of a fork
        cycle(1, 32'hCAFE_F00D, 9'h0F0, '0);
        cycle(0, '0, '0, 9'h010);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_valid", oValid, 0);
        chk("t5_ready", oReady, 1);
        tokQ.delete();
        doneDue = 1'b0;
        dropDue = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            expDeliv[k] = 0;
            obsDeliv[k] = 0;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        cycle(0, '0, '0, '1);
        cycle(0, '0, '0, '1);

        // random traffic
        for (int n = 0; n < 2000; n++) begin
            logic [NUM_CH-1:0] s;
            s = NUM_CH'($urandom);
            if ($urandom_range(0, 7) == 0) s = '0;
            cycle(1'($urandom_range(0, 1)), DATA_W'($urandom), s, NUM_CH'($urandom));
        end
        for (int n = 0; n < 4; n++) cycle(0, '0, '0, '1);
        for (int k = 0; k < NUM_CH; k++) chk($sformatf("deliv%0d", k), obsDeliv[k], expDeliv[k]);

`ifdef SEL_SPLIT_STAT_EN
        iClr = 1'b1;
        cycle(0, '0, '0, '1);
        iClr = 1'b0;
        chk("cnt_clr0", oCnt, 0);
        for (int n = 0; n < 70000; n++) cycle(1, DATA_W'(n), 9'h001, '1);
        cycle(0, '0, '0, '1);
        cycle(0, '0, '0, '1);
        chk("cnt_ch0", oCnt[15:0], 16'd4464);
        chk("cnt_rest", oCnt[NUM_CH*16-1:16], 0);
        iClr = 1'b1;
        cycle(0, '0, '0, '1);
        iClr = 1'b0;
        chk("cnt_clr", oCnt, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
